// File: rtl/alarm_pkg.sv
// Shared widths and state encoding for the alarm sequencer.
package alarm_pkg;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;
endpackage

// File: rtl/alarm_trigger_second_timer.sv
// Seconds counter shared by the ring and snooze phases; done pulses on the tick
// that finds the count already at the terminal value.
module second_timer #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] terminal,
    output logic         done
);
    logic [W-1:0] count;

    // Holding at terminal keeps the counter from wrapping if clear is late.
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (tick && count != terminal)
            count <= count + 1'b1;
    end

    assign done = tick & (count == terminal);
endmodule

// File: rtl/alarm_trigger.sv
// Alarm sequencer: time comparator plus IDLE/RINGING/SNOOZE FSM driving play_sound.
// Valid/ready is not used here: buttons and tick_1hz are single-cycle pulses, sampled once.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              alarm_enable,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              play_sound,
    output logic              snoozing,
    output logic [1:0]        snooze_count,
    output state_t            state
);
    localparam int MAX_SEC = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
    localparam int CNT_W   = $clog2(MAX_SEC);
    localparam logic [CNT_W-1:0] RING_TC   = CNT_W'(RING_SECONDS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_TC = CNT_W'(SNOOZE_SECONDS - 1);
    localparam logic [1:0]       MAX_CNT   = 2'(MAX_SNOOZE);

    logic match;
    logic snooze_accept;
    logic timer_clear;
    logic timer_done;

    // Only the :00 second of the alarm minute triggers.
    assign match = tick_1hz & alarm_enable & (cur_hour == alarm_hour) &
                   (cur_min == alarm_min) & (cur_sec == '0);

    assign snooze_accept = snooze_btn & (snooze_count < MAX_CNT);

    // Counter restarts on every state entry and stays cleared while idle.
    assign timer_clear = ~alarm_enable | (state == IDLE) | stop_btn |
                         ((state == RINGING) & snooze_accept) | timer_done;

    second_timer #(.W(CNT_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear),
        .tick     (tick_1hz),
        .terminal ((state == SNOOZE) ? SNOOZE_TC : RING_TC),
        .done     (timer_done)
    );

    always_ff @(posedge clock) begin
        if (reset || !alarm_enable) begin
            state        <= IDLE;
            play_sound   <= 1'b0;
            snoozing     <= 1'b0;
            snooze_count <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state        <= RINGING;
                        play_sound   <= 1'b1;
                        snoozing     <= 1'b0;
                        snooze_count <= 2'd0;
                    end
                end
                RINGING: begin
                    if (stop_btn) begin
                        state      <= IDLE;
                        play_sound <= 1'b0;
                    end else if (snooze_accept || (timer_done && snooze_count < MAX_CNT)) begin
                        state        <= SNOOZE;
                        play_sound   <= 1'b0;
                        snoozing     <= 1'b1;
                        snooze_count <= snooze_count + 2'd1;
                    end else if (timer_done) begin
                        state      <= IDLE;
                        play_sound <= 1'b0;
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state    <= IDLE;
                        snoozing <= 1'b0;
                    end else if (timer_done) begin
                        state      <= RINGING;
                        play_sound <= 1'b1;
                        snoozing   <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    play_sound <= 1'b0;
                    snoozing   <= 1'b0;
                end
            endcase
        end
    end
endmodule
